// File: rtl/perf_ctrl_pkg.sv
// Shared types for the perf window controller: FSM states, end causes and the
// layout of one history entry.
package perf_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RUNNING = 2'd2,
    DRAIN   = 2'd3
  } ctrl_state_e;

  typedef enum logic [1:0] {
    CAUSE_DONE    = 2'd0,
    CAUSE_TIMEOUT = 2'd1,
    CAUSE_ABORT   = 2'd2
  } end_cause_e;

  localparam int COUNTER_WIDTH_DEFAULT = 32;
  localparam int DRAIN_MAX_DEFAULT     = 8;

  // Field order matches the flat vector pushed into the history FIFO (MSB first).
  typedef struct packed {
    logic [COUNTER_WIDTH_DEFAULT-1:0] total;
    logic [COUNTER_WIDTH_DEFAULT-1:0] active;
    logic [31:0]                      stall;
    end_cause_e                       cause;
  } hist_entry_t;

endpackage

// File: rtl/perf_hist_fifo.sv
// Synchronous show-ahead FIFO. The head entry is held in a register so the
// read-side outputs come straight from flops.
module perf_hist_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] head_reg, head_next;
  logic             nonempty_reg, full_reg;
  logic             do_push, do_pop;

  // A full FIFO still accepts a push when the same cycle frees a slot.
  assign do_pop      = pop && nonempty_reg;
  assign do_push     = push && (!full_reg || do_pop);
  assign rd_ptr_next = rd_ptr_reg + AW'(do_pop);
  assign count_next  = count_reg + CW'(do_push) - CW'(do_pop);

  // Next head is the incoming word when it lands exactly at the new read slot.
  always_comb begin
    head_next = mem[rd_ptr_next];
    if (do_push && (wr_ptr_reg == rd_ptr_next)) begin
      head_next = push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      head_reg     <= '0;
      nonempty_reg <= 1'b0;
      full_reg     <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      head_reg     <= head_next;
      nonempty_reg <= (count_next != '0);
      full_reg     <= (count_next == CW'(DEPTH));
    end
  end

  assign head_data = head_reg;
  assign count     = count_reg;
  assign full      = full_reg;
  assign empty     = ~nonempty_reg;

endmodule

// File: rtl/perf_window_ctrl.sv
// Measurement-window sequencer for the perf monitor: issues start/done pulses,
// waits for the latched counters and logs them into a small history FIFO.
module perf_window_ctrl
  import perf_ctrl_pkg::*;
#(
  parameter int COUNTER_WIDTH = 32,
  parameter int HIST_DEPTH    = 4,
  parameter int TIMEOUT_W     = 24,
  parameter int DRAIN_MAX     = DRAIN_MAX_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          csr_arm,
  input  logic                          csr_abort,
  input  logic                          csr_auto,
  input  logic                          csr_continuous,
  input  logic [TIMEOUT_W-1:0]          csr_timeout,
  input  logic                          csr_clear_flags,
  input  logic                          accel_start_pulse,
  input  logic                          accel_done_pulse,
  output logic                          perf_start_pulse,
  output logic                          perf_done_pulse,
  input  logic                          perf_measurement_done,
  input  logic [COUNTER_WIDTH-1:0]      perf_total_cycles,
  input  logic [COUNTER_WIDTH-1:0]      perf_active_cycles,
  input  logic [31:0]                   perf_stall_cycles,
  input  logic                          hist_rd_en,
  output logic                          hist_rd_valid,
  output logic [COUNTER_WIDTH-1:0]      hist_rd_total,
  output logic [COUNTER_WIDTH-1:0]      hist_rd_active,
  output logic [31:0]                   hist_rd_stall,
  output logic [1:0]                    hist_rd_cause,
  output logic [$clog2(HIST_DEPTH):0]   hist_count,
  output logic                          hist_overflow,
  output logic                          drain_err,
  output logic [1:0]                    ctrl_state,
  output logic                          ctrl_busy
);

  localparam int ENTRY_W = 2 * COUNTER_WIDTH + 32 + 2;
  localparam int DCW     = $clog2(DRAIN_MAX) + 1;

  ctrl_state_e          state_reg;
  end_cause_e           cause_reg;
  logic [TIMEOUT_W-1:0] tmo_cnt_reg;
  logic [DCW-1:0]       drain_cnt_reg;
  logic                 busy_reg;
  logic                 perf_start_pulse_reg, perf_done_pulse_reg;
  logic                 hist_overflow_reg, drain_err_reg;

  logic                 trigger, tmo_hit, run_end;
  logic                 capture, drain_expire, overflow_set;
  logic [ENTRY_W-1:0]   push_data, head_data;
  logic                 fifo_full, fifo_empty;

  assign trigger      = csr_auto ? accel_start_pulse : 1'b1;
  assign tmo_hit      = (csr_timeout != '0) && (tmo_cnt_reg == TIMEOUT_W'(1));
  assign run_end      = accel_done_pulse || csr_abort || tmo_hit;
  assign capture      = (state_reg == DRAIN) && perf_measurement_done;
  assign drain_expire = (state_reg == DRAIN) && !perf_measurement_done &&
                        (drain_cnt_reg == DCW'(DRAIN_MAX - 1));
  // A full FIFO always has a valid head, so hist_rd_en alone means a real pop.
  assign overflow_set = capture && fifo_full && !hist_rd_en;
  assign push_data    = {perf_total_cycles, perf_active_cycles, perf_stall_cycles, cause_reg};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg            <= IDLE;
      cause_reg            <= CAUSE_DONE;
      tmo_cnt_reg          <= '0;
      drain_cnt_reg        <= '0;
      busy_reg             <= 1'b0;
      perf_start_pulse_reg <= 1'b0;
      perf_done_pulse_reg  <= 1'b0;
      hist_overflow_reg    <= 1'b0;
      drain_err_reg        <= 1'b0;
    end else begin
      perf_start_pulse_reg <= 1'b0;
      perf_done_pulse_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (csr_arm) begin
            state_reg <= ARMED;
            busy_reg  <= 1'b1;
          end
        end
        ARMED: begin
          if (csr_abort) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else if (trigger) begin
            perf_start_pulse_reg <= 1'b1;
            tmo_cnt_reg          <= csr_timeout;
            state_reg            <= RUNNING;
          end
        end
        RUNNING: begin
          if (run_end) begin
            perf_done_pulse_reg <= 1'b1;
            cause_reg     <= accel_done_pulse ? CAUSE_DONE :
                             (csr_abort ? CAUSE_ABORT : CAUSE_TIMEOUT);
            drain_cnt_reg <= '0;
            state_reg     <= DRAIN;
          end else if (tmo_cnt_reg != '0) begin
            tmo_cnt_reg <= tmo_cnt_reg - TIMEOUT_W'(1);
          end
        end
        DRAIN: begin
          if (perf_measurement_done) begin
            state_reg <= csr_continuous ? ARMED : IDLE;
            busy_reg  <= csr_continuous;
          end else if (drain_expire) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else begin
            drain_cnt_reg <= drain_cnt_reg + DCW'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
      // Set beats clear when both land in the same cycle.
      hist_overflow_reg <= overflow_set || (hist_overflow_reg && !csr_clear_flags);
      drain_err_reg     <= drain_expire || (drain_err_reg && !csr_clear_flags);
    end
  end

  perf_hist_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (HIST_DEPTH)
  ) u_hist (
    .clk       (clk),
    .rst       (rst),
    .push      (capture),
    .push_data (push_data),
    .pop       (hist_rd_en),
    .head_data (head_data),
    .count     (hist_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign hist_rd_valid    = ~fifo_empty;
  assign hist_rd_total    = head_data[ENTRY_W-1 -: COUNTER_WIDTH];
  assign hist_rd_active   = head_data[COUNTER_WIDTH+33 -: COUNTER_WIDTH];
  assign hist_rd_stall    = head_data[33:2];
  assign hist_rd_cause    = head_data[1:0];
  assign perf_start_pulse = perf_start_pulse_reg;
  assign perf_done_pulse  = perf_done_pulse_reg;
  assign hist_overflow    = hist_overflow_reg;
  assign drain_err        = drain_err_reg;
  assign ctrl_state       = state_reg;
  assign ctrl_busy        = busy_reg;

endmodule

// File: tb/tb_perf_window_ctrl.sv
// Directed bench for perf_window_ctrl with a small behavioural perf model that
// counts cycles from perf_start_pulse to perf_done_pulse and answers later.
module tb_perf_window_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        csr_arm = 1'b0, csr_abort = 1'b0, csr_auto = 1'b0, csr_continuous = 1'b0;
  logic [23:0] csr_timeout = '0;
  logic        csr_clear_flags = 1'b0;
  logic        accel_start_pulse = 1'b0, accel_done_pulse = 1'b0;
  logic        perf_start_pulse, perf_done_pulse;
  logic        perf_measurement_done = 1'b0;
  logic [31:0] perf_total_cycles = '0, perf_active_cycles = '0, perf_stall_cycles = '0;
  logic        hist_rd_en = 1'b0;
  logic        hist_rd_valid;
  logic [31:0] hist_rd_total, hist_rd_active, hist_rd_stall;
  logic [1:0]  hist_rd_cause;
  logic [2:0]  hist_count;
  logic        hist_overflow, drain_err;
  logic [1:0]  ctrl_state;
  logic        ctrl_busy;

  int checks = 0;
  int errors = 0;

  perf_window_ctrl #(
    .COUNTER_WIDTH (32),
    .HIST_DEPTH    (4),
    .TIMEOUT_W     (24),
    .DRAIN_MAX     (8)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .csr_arm               (csr_arm),
    .csr_abort             (csr_abort),
    .csr_auto              (csr_auto),
    .csr_continuous        (csr_continuous),
    .csr_timeout           (csr_timeout),
    .csr_clear_flags       (csr_clear_flags),
    .accel_start_pulse     (accel_start_pulse),
    .accel_done_pulse      (accel_done_pulse),
    .perf_start_pulse      (perf_start_pulse),
    .perf_done_pulse       (perf_done_pulse),
    .perf_measurement_done (perf_measurement_done),
    .perf_total_cycles     (perf_total_cycles),
    .perf_active_cycles    (perf_active_cycles),
    .perf_stall_cycles     (perf_stall_cycles),
    .hist_rd_en            (hist_rd_en),
    .hist_rd_valid         (hist_rd_valid),
    .hist_rd_total         (hist_rd_total),
    .hist_rd_active        (hist_rd_active),
    .hist_rd_stall         (hist_rd_stall),
    .hist_rd_cause         (hist_rd_cause),
    .hist_count            (hist_count),
    .hist_overflow         (hist_overflow),
    .drain_err             (drain_err),
    .ctrl_state            (ctrl_state),
    .ctrl_busy             (ctrl_busy)
  );

  always #5 clk = ~clk;

  // Perf model: stall field carries the run number so entries can be identified.
  int cyc = 0, n_start = 0, n_done = 0, start_cyc = 0, done_cyc = 0;
  int pcnt = 0, pdly = 0;
  bit prun = 1'b0, perf_mute = 1'b0;

  always @(negedge clk) begin
    cyc++;
    perf_measurement_done = 1'b0;
    if (perf_start_pulse) begin n_start++; start_cyc = cyc; end
    if (perf_done_pulse)  begin n_done++;  done_cyc  = cyc; end
    if (rst) begin
      prun = 1'b0;
      pdly = 0;
    end else begin
      if (pdly != 0) begin
        pdly--;
        if (pdly == 0 && !perf_mute) begin
          perf_measurement_done = 1'b1;
          perf_total_cycles     = pcnt;
          perf_active_cycles    = pcnt - 1;
          perf_stall_cycles     = n_start;
        end
      end
      if (perf_start_pulse) begin
        pcnt = 1;
        prun = 1'b1;
      end else if (prun) begin
        pcnt++;
        if (perf_done_pulse) begin
          prun = 1'b0;
          pdly = 2;
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [1:0] s, input int max, input string tag);
    int k = 0;
    while (ctrl_state !== s && k < max) begin step(); k++; end
    check(tag, ctrl_state, s);
  endtask

  task automatic wait_valid(input int max, input string tag);
    int k = 0;
    while (hist_rd_valid !== 1'b1 && k < max) begin step(); k++; end
    check(tag, hist_rd_valid, 1);
  endtask

  task automatic arm();
    csr_arm = 1'b1; step(); csr_arm = 1'b0;
  endtask

  task automatic pulse_done();
    accel_done_pulse = 1'b1; step(); accel_done_pulse = 1'b0;
  endtask

  task automatic pop();
    $display("pop: total=%0d active=%0d stall=%0d cause=%0d count=%0d",
             hist_rd_total, hist_rd_active, hist_rd_stall, hist_rd_cause, hist_count);
    hist_rd_en = 1'b1; step(); hist_rd_en = 1'b0;
  endtask

  int base, s0, d0, k;
  int exp_ids[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step(3);
    rst = 1'b0;
    step();
    check("rst_state", ctrl_state, 0);
    check("rst_busy", ctrl_busy, 0);
    check("rst_valid", hist_rd_valid, 0);
    check("rst_count", hist_count, 0);
    check("rst_ovf", hist_overflow, 0);
    check("rst_derr", drain_err, 0);
    check("rst_start", perf_start_pulse, 0);
    check("rst_done", perf_done_pulse, 0);

    // Auto mode, done 100 cycles after accel start
    $display("run: auto mode, accel_done after 100 cycles");
    csr_auto = 1'b1;
    arm();
    check("t1_armed", ctrl_state, 1);
    check("t1_busy", ctrl_busy, 1);
    step(3);
    check("t1_still_armed", ctrl_state, 1);
    accel_start_pulse = 1'b1; step(); accel_start_pulse = 1'b0;
    check("t1_start_pulse", perf_start_pulse, 1);
    check("t1_running", ctrl_state, 2);
    step();
    check("t1_start_one_cycle", perf_start_pulse, 0);
    step(98);
    pulse_done();
    check("t1_done_pulse", perf_done_pulse, 1);
    check("t1_drain", ctrl_state, 3);
    wait_valid(20, "t1_valid");
    check("t1_total", hist_rd_total, 101);
    check("t1_active", hist_rd_active, 100);
    check("t1_stall", hist_rd_stall, 1);
    check("t1_cause", hist_rd_cause, 0);
    check("t1_idle", ctrl_state, 0);
    check("t1_count", hist_count, 1);
    check("t1_nstart", n_start, 1);
    check("t1_ndone", n_done, 1);
    pop();
    check("t1_pop_count", hist_count, 0);
    check("t1_pop_valid", hist_rd_valid, 0);

    // Timeout of 50 cycles
    $display("run: timeout 50");
    csr_auto = 1'b0;
    csr_timeout = 24'd50;
    arm();
    wait_valid(100, "t2_valid");
    check("t2_done_minus_start", done_cyc - start_cyc, 50);
    check("t2_cause", hist_rd_cause, 1);
    check("t2_total", hist_rd_total, 51);
    check("t2_idle", ctrl_state, 0);
    pop();
    csr_timeout = '0;

    // Done and abort together; abort in DRAIN ignored
    $display("run: done+abort same cycle");
    arm();
    wait_state(2, 10, "t3a_running");
    step(3);
    accel_done_pulse = 1'b1; csr_abort = 1'b1; step();
    accel_done_pulse = 1'b0; csr_abort = 1'b0;
    check("t3a_drain", ctrl_state, 3);
    csr_abort = 1'b1; step(); csr_abort = 1'b0;
    check("t3a_abort_in_drain", ctrl_state, 3);
    wait_valid(20, "t3a_valid");
    check("t3a_cause", hist_rd_cause, 0);
    pop();

    // Abort while armed, and in IDLE
    $display("run: abort while armed");
    csr_auto = 1'b1;
    arm();
    check("t3b_armed", ctrl_state, 1);
    s0 = n_start; d0 = n_done;
    csr_abort = 1'b1; step(); csr_abort = 1'b0;
    check("t3b_idle", ctrl_state, 0);
    check("t3b_busy", ctrl_busy, 0);
    step(3);
    check("t3b_no_start", n_start, s0);
    check("t3b_no_done", n_done, d0);
    check("t3b_fifo", hist_count, 0);
    csr_abort = 1'b1; step(); csr_abort = 1'b0;
    check("t3b_idle_abort", ctrl_state, 0);

    // Abort while running
    $display("run: abort while running");
    csr_auto = 1'b0;
    arm();
    wait_state(2, 10, "t3c_running");
    step(2);
    csr_abort = 1'b1; step(); csr_abort = 1'b0;
    check("t3c_done_pulse", perf_done_pulse, 1);
    wait_valid(20, "t3c_valid");
    check("t3c_cause", hist_rd_cause, 2);
    pop();

    // Continuous: five runs into a four-deep FIFO
    $display("run: continuous x5, no reads");
    base = n_start;
    csr_continuous = 1'b1;
    arm();
    for (int r = 1; r <= 5; r++) begin
      wait_state(2, 20, "t4_running");
      if (r == 5) csr_continuous = 1'b0;
      step(2);
      pulse_done();
      k = 0;
      while (ctrl_state === 2'd3 && k < 20) begin step(); k++; end
      check("t4_left_drain", (ctrl_state !== 2'd3), 1);
    end
    check("t4_count", hist_count, 4);
    check("t4_ovf", hist_overflow, 1);
    check("t4_idle", ctrl_state, 0);
    check("t4_head", hist_rd_stall, base + 1);

    // Push and pop in the same cycle while full
    $display("run: push+pop while full");
    arm();
    wait_state(2, 10, "t4b_running");
    step(2);
    pulse_done();
    k = 0;
    while (perf_measurement_done !== 1'b1 && k < 20) begin step(); k++; end
    check("t4b_md_seen", perf_measurement_done, 1);
    pop();
    check("t4b_count", hist_count, 4);
    check("t4b_head", hist_rd_stall, base + 2);
    exp_ids[0] = base + 2; exp_ids[1] = base + 3;
    exp_ids[2] = base + 4; exp_ids[3] = base + 6;
    for (int i = 0; i < 4; i++) begin
      check("t4b_drain_valid", hist_rd_valid, 1);
      check("t4b_drain_id", hist_rd_stall, exp_ids[i]);
      pop();
    end
    check("t4b_empty", hist_rd_valid, 0);
    check("t4b_empty_count", hist_count, 0);

    // No measurement_done: drain timeout
    $display("run: drain timeout");
    perf_mute = 1'b1;
    csr_continuous = 1'b1;
    csr_timeout = 24'd5;
    arm();
    k = 0;
    while (perf_done_pulse !== 1'b1 && k < 20) begin step(); k++; end
    check("t5_done_pulse", perf_done_pulse, 1);
    k = 0;
    while (drain_err !== 1'b1 && k < 20) begin step(); k++; end
    check("t5_drain_delay", k, 8);
    check("t5_idle", ctrl_state, 0);
    check("t5_no_push", hist_count, 0);
    csr_continuous = 1'b0;
    csr_clear_flags = 1'b1; step(); csr_clear_flags = 1'b0;
    check("t5_derr_clr", drain_err, 0);
    check("t5_ovf_clr", hist_overflow, 0);
    perf_mute = 1'b0;
    csr_timeout = '0;
    step(4);

    // Reset in the middle of a run
    $display("run: reset while running");
    arm();
    wait_state(2, 10, "t6a_running");
    step(2);
    pulse_done();
    wait_valid(20, "t6a_valid");
    arm();
    wait_state(2, 10, "t6_running");
    step(3);
    d0 = n_done;
    rst = 1'b1; step();
    check("t6_state", ctrl_state, 0);
    check("t6_busy", ctrl_busy, 0);
    check("t6_start", perf_start_pulse, 0);
    check("t6_done", perf_done_pulse, 0);
    check("t6_valid", hist_rd_valid, 0);
    check("t6_count", hist_count, 0);
    rst = 1'b0;
    step(5);
    check("t6_no_done_pulse", n_done, d0);
    check("t6_idle_after", ctrl_state, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/perf_window_ctrl.md
Name: perf_window_ctrl

Overview:
- Sequences the performance monitor (perf). Generates its start_pulse/done_pulse around accelerator runs, and captures the latched counter results when measurement_done fires.
- Stores results in a small history FIFO read by the CSR block.
- Adds arm/auto-trigger/continuous modes, a per-run cycle timeout, software abort, and sticky error flags.

Parameters:
- COUNTER_WIDTH, 32, width of the perf cycle counters captured.
- HIST_DEPTH, 4, history FIFO entries; power of 2, ≥2.
- TIMEOUT_W, 24, width of the run timeout counter.
- DRAIN_MAX, 8, maximum cycles to wait for perf_measurement_done after perf_done_pulse.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- csr_arm  in  1  pulse; arm a measurement window
- csr_abort  in  1  pulse; end or cancel the current window
- csr_auto  in  1  1 = wait for accel_start_pulse; 0 = start immediately when armed
- csr_continuous  in  1  1 = re-arm automatically after each capture
- csr_timeout  in  TIMEOUT_W  maximum RUNNING cycles; 0 = disabled
- csr_clear_flags  in  1  pulse; clears sticky flags
- accel_start_pulse  in  1  accelerator run start
- accel_done_pulse  in  1  accelerator run done
- perf_start_pulse  out  1  to perf.start_pulse
- perf_done_pulse  out  1  to perf.done_pulse
- perf_measurement_done  in  1  from perf
- perf_total_cycles  in  COUNTER_WIDTH  from perf
- perf_active_cycles  in  COUNTER_WIDTH  from perf
- perf_stall_cycles  in  32  from perf
- hist_rd_en  in  1  pop the head entry
- hist_rd_valid  out  1  FIFO non-empty
- hist_rd_total  out  COUNTER_WIDTH  head entry: total cycles
- hist_rd_active  out  COUNTER_WIDTH  head entry: active cycles
- hist_rd_stall  out  32  head entry: stall cycles
- hist_rd_cause  out  2  head entry end cause: 0 = done, 1 = timeout, 2 = abort
- hist_count  out  $clog2(HIST_DEPTH)+1  number of occupied entries
- hist_overflow  out  1  sticky; a capture was dropped because the FIFO was full
- drain_err  out  1  sticky; measurement_done not received within DRAIN_MAX cycles
- ctrl_state  out  2  current FSM state encoding
- ctrl_busy  out  1  state ≠ IDLE

Behaviour:
- Reset (rst = 1 at a clk edge) drives every output and internal register to 0, state to IDLE, and empties the FIFO. Reset mid-window issues no perf_done_pulse.
- All outputs are registered. perf_start_pulse and perf_done_pulse are one-cycle pulses, asserted the cycle after the transition decision.
- FSM states: IDLE = 0, ARMED = 1, RUNNING = 2, DRAIN = 3.
- IDLE:
  - csr_arm → ARMED.
  - csr_abort → no effect.
- ARMED:
  - csr_abort → IDLE, no pulses issued.
  - Trigger = csr_auto ? accel_start_pulse : 1. On trigger: perf_start_pulse, load tmo_cnt ← csr_timeout, → RUNNING.
  - Abort has priority over trigger in the same cycle.
- RUNNING:
  - End condition, with priority done > abort > timeout:
    - accel_done_pulse → cause 0
    - csr_abort → cause 1 is not used here; cause 2
    - csr_timeout ≠ 0 and tmo_cnt == 1 → cause 1
  - On end: perf_done_pulse, latch cause, clear drain counter, → DRAIN.
  - Otherwise tmo_cnt decrements each cycle when non-zero, so RUNNING lasts at most csr_timeout cycles.
  - accel_start_pulse in RUNNING is ignored.
- DRAIN:
  - perf_measurement_done → push {total, active, stall, cause}, then → ARMED if csr_continuous, else → IDLE.
  - Drain counter reaches DRAIN_MAX without measurement_done → set drain_err, no push, → IDLE (regardless of csr_continuous).
  - csr_abort in DRAIN is ignored.
- csr_arm outside IDLE is ignored.
- FIFO:
  - Show-ahead: head data is valid while hist_rd_valid.
  - hist_rd_en with an empty FIFO is a no-op.
  - Push while full with no pop in the same cycle → drop the new entry, set hist_overflow.
  - Push and pop in the same cycle while full → both succeed; count unchanged.
  - Pointers wrap modulo HIST_DEPTH.
- Sticky flags: csr_clear_flags clears both. If a set and a clear occur in the same cycle, the set wins.
- perf_measurement_done outside DRAIN is ignored.

Decomposition:
- Package perf_ctrl_pkg contains:
  - state enum: IDLE, ARMED, RUNNING, DRAIN
  - end-cause enum: CAUSE_DONE, CAUSE_TIMEOUT, CAUSE_ABORT
  - hist entry struct: {total, active, stall, cause}
  - DRAIN_MAX default
- One sub-module, perf_hist_fifo: synchronous show-ahead FIFO parameterised by entry width and depth, with count, full, and empty outputs.

Test Plan:
- Auto mode, csr_timeout = 0: arm, then accel_start at t0 and accel_done 100 cycles later → one perf_start and one perf_done pulse; a single entry with cause 0 and total matching perf (101); back in IDLE.
- csr_timeout = 50, no accel_done → perf_done_pulse exactly 50 cycles after perf_start_pulse; entry cause 1.
- accel_done_pulse and csr_abort in the same RUNNING cycle → cause 0. csr_abort while ARMED → IDLE, no perf pulses, FIFO unchanged.
- csr_continuous = 1 with 5 runs and HIST_DEPTH = 4, no reads → hist_count = 4, hist_overflow = 1, entries 1–4 retained. Then push and pop in the same cycle while full → count stays 4.
- Tie perf_measurement_done low → drain_err set 8 cycles after perf_done_pulse, state IDLE, no push. csr_clear_flags → drain_err = 0.
- Assert rst during RUNNING → all outputs 0 the next cycle, no perf_done_pulse, FIFO empty.
